// File: rtl/fifo_word_packer.sv
// Packs bytes from a byte FIFO into little-endian 32-bit words, with an optional
// flush that emits a partial word once any in-flight read has landed.
module fifo_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic        fifo_wr_en,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  input  logic        flush,
  output logic [31:0] word_out,
  output logic [2:0]  word_bytes,
  output logic        word_valid,
  input  logic        word_ready
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] OUT  = 1'b1;

  logic [0:0]  state_r;
  logic [2:0]  byte_cnt_r;
  logic        rd_pend_r;
  logic        flush_pend_r;
  logic [31:0] word_r;
  logic [2:0]  bytes_r;
  logic        valid_r;

  logic [2:0]  occupancy_s;
  logic [2:0]  cnt_next_s;
  logic [31:0] word_next_s;
  logic        rd_en_s;
  logic        flush_take_s;

  // Bytes already landed plus the one still in flight; bounds further reads.
  always_comb begin
    occupancy_s  = byte_cnt_r + {2'b00, rd_pend_r};
    rd_en_s      = rst & (state_r == FILL) & ~fifo_empty & ~fifo_wr_en
                   & (occupancy_s < 3'd4) & ~flush_pend_r;
    flush_take_s = (state_r == FILL) & flush & (occupancy_s != 3'd0);
  end

  // Merge the returning FIFO byte into the lane selected by the current count.
  always_comb begin
    word_next_s = word_r;
    cnt_next_s  = byte_cnt_r;
    if (rd_pend_r) begin
      case (byte_cnt_r[1:0])
        2'd0:    word_next_s[7:0]   = fifo_data;
        2'd1:    word_next_s[15:8]  = fifo_data;
        2'd2:    word_next_s[23:16] = fifo_data;
        2'd3:    word_next_s[31:24] = fifo_data;
        default: word_next_s        = word_r;
      endcase
      cnt_next_s = byte_cnt_r + 3'd1;
    end else begin
      cnt_next_s = byte_cnt_r;
    end
  end

  // Packer state machine; words are held in OUT until the downstream handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= FILL;
      byte_cnt_r   <= 3'd0;
      rd_pend_r    <= 1'b0;
      flush_pend_r <= 1'b0;
      word_r       <= 32'd0;
      bytes_r      <= 3'd0;
      valid_r      <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          rd_pend_r  <= rd_en_s;
          byte_cnt_r <= cnt_next_s;
          word_r     <= word_next_s;
          if (cnt_next_s == 3'd4) begin
            state_r      <= OUT;
            valid_r      <= 1'b1;
            bytes_r      <= 3'd4;
            flush_pend_r <= 1'b0;
          end else if (flush_pend_r && !rd_pend_r) begin
            // Reads are blocked while flush is pending, so the count is final here.
            state_r      <= OUT;
            valid_r      <= 1'b1;
            bytes_r      <= byte_cnt_r;
            flush_pend_r <= 1'b0;
          end else if (flush_take_s) begin
            flush_pend_r <= 1'b1;
          end else begin
            flush_pend_r <= flush_pend_r;
          end
        end
        OUT: begin
          rd_pend_r <= 1'b0;
          if (valid_r && word_ready) begin
            state_r    <= FILL;
            byte_cnt_r <= 3'd0;
            word_r     <= 32'd0;
            bytes_r    <= 3'd0;
            valid_r    <= 1'b0;
          end else begin
            state_r <= OUT;
          end
        end
        default: begin
          state_r      <= FILL;
          byte_cnt_r   <= 3'd0;
          rd_pend_r    <= 1'b0;
          flush_pend_r <= 1'b0;
          word_r       <= 32'd0;
          bytes_r      <= 3'd0;
          valid_r      <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en_s;
  assign word_out   = word_r;
  assign word_bytes = bytes_r;
  assign word_valid = valid_r;

endmodule
